// File: rtl/arbiter_pkg.sv
// Shared types for the weighted round-robin arbiter.
package arbiter_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arbState_t;

endpackage

// File: rtl/arbiter_rr_find.sv
// Round-robin search: first set request strictly after i_ptr, wrapping around.
module arbiter_rr_find #(
  parameter  int CLIENTS = 8,
  localparam int N       = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0] i_req,
  input  logic [N-1:0]       i_ptr,
  output logic [N-1:0]       o_idx,
  output logic               o_found
);

  logic [2*CLIENTS-1:0] w_dbl;
  logic [N:0]           w_shift;
  logic [N:0]           w_sum;
  logic [CLIENTS-1:0]   w_rot;
  logic [N-1:0]         w_off;

  // Shifting the doubled vector puts client ptr+1 at bit 0 for any CLIENTS.
  assign w_dbl   = {i_req, i_req};
  assign w_shift = {1'b0, i_ptr} + (N+1)'(1);
  assign w_rot   = CLIENTS'(w_dbl >> w_shift);

  always_comb begin
    w_off = '0;
    for (int i = CLIENTS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = N'(i);
    end
  end

  assign w_sum   = w_shift + {1'b0, w_off};
  assign o_idx   = (w_sum >= (N+1)'(CLIENTS)) ? N'(w_sum - (N+1)'(CLIENTS)) : N'(w_sum);
  assign o_found = |w_rot;

endmodule

// File: rtl/arbiter_weighted_round_robin.sv
// Weighted round-robin arbiter: held grants, per-client credit bursts,
// zero-bubble handover on acknowledge.
module arbiter_weighted_round_robin
  import arbiter_pkg::*;
#(
  parameter  int CLIENTS  = 8,
  parameter  int WEIGHT_W = 4,
  localparam int N        = $clog2(CLIENTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_block_arb,
  input  logic [CLIENTS-1:0]    i_req,
  input  logic [CLIENTS*WEIGHT_W-1:0] i_weight,
  input  logic                  i_gnt_ack,
  output logic [CLIENTS-1:0]    o_gnt,
  output logic [N-1:0]          o_gnt_id,
  output logic                  o_gnt_valid
);

  arbState_t           r_state;
  arbState_t           w_nextState;
  logic [N-1:0]        r_gntId;
  logic [N-1:0]        r_last;
  logic [N-1:0]        w_nextId;
  logic [N-1:0]        w_ptr;
  logic [N-1:0]        w_winIdx;
  logic [CLIENTS-1:0]  r_gnt;
  logic [CLIENTS-1:0]  w_elig;
  logic                r_valid;
  logic                w_found;
  logic                w_load;
  logic                w_dec;
  logic                w_updLast;
  logic                w_burst;
  logic [WEIGHT_W-1:0] r_credit  [CLIENTS];
  logic [WEIGHT_W-1:0] w_weights [CLIENTS];
  logic [WEIGHT_W-1:0] w_curCredit;
  logic [WEIGHT_W-1:0] w_decCredit;
  logic [WEIGHT_W-1:0] w_reload;

  always_comb begin
    for (int k = 0; k < CLIENTS; k++) begin
      w_weights[k] = i_weight[k*WEIGHT_W +: WEIGHT_W];
    end
  end

  assign w_elig = i_block_arb ? '0 : i_req;

  // While granted, the search starts after the current owner, which is
  // where the last-granted pointer will sit once the grant is released.
  assign w_ptr = (r_state == ARB_GRANT) ? r_gntId : r_last;

  arbiter_rr_find #(
    .CLIENTS (CLIENTS)
  ) u_find (
    .i_req   (w_elig),
    .i_ptr   (w_ptr),
    .o_idx   (w_winIdx),
    .o_found (w_found)
  );

  assign w_curCredit = r_credit[r_gntId];
  assign w_decCredit = w_curCredit - WEIGHT_W'(1);
  assign w_burst     = (w_decCredit != '0) && w_elig[r_gntId];
  assign w_reload    = (w_weights[w_winIdx] == '0) ? WEIGHT_W'(1) : w_weights[w_winIdx];

  always_comb begin
    w_nextState = r_state;
    w_nextId    = r_gntId;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_updLast   = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        w_nextId = '0;
        if (w_found) begin
          w_nextState = ARB_GRANT;
          w_nextId    = w_winIdx;
          w_load      = 1'b1;
        end
      end
      ARB_GRANT: begin
        if (i_gnt_ack) begin
          w_dec = 1'b1;
          if (!w_burst) begin
            w_updLast = 1'b1;
            if (w_found) begin
              w_nextId = w_winIdx;
              w_load   = 1'b1;
            end else begin
              w_nextState = ARB_IDLE;
              w_nextId    = '0;
            end
          end
        end
      end
      default: begin
        w_nextState = ARB_IDLE;
        w_nextId    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_gntId <= '0;
      r_valid <= 1'b0;
      r_last  <= N'(CLIENTS - 1);
    end else begin
      r_state <= w_nextState;
      r_gntId <= w_nextId;
      r_gnt   <= (w_nextState == ARB_GRANT) ? (CLIENTS'(1) << w_nextId) : '0;
      r_valid <= (w_nextState == ARB_GRANT);
      if (w_updLast) r_last <= r_gntId;
    end
  end

  // A reload for the new winner overrides the decrement when the sole
  // eligible client wins again.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < CLIENTS; k++) r_credit[k] <= '0;
    end else begin
      if (w_dec)  r_credit[r_gntId]  <= w_decCredit;
      if (w_load) r_credit[w_winIdx] <= w_reload;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_gnt_id    = r_gntId;
  assign o_gnt_valid = r_valid;

endmodule

// File: tb/tb_arbiter_weighted_round_robin.sv
// Scoreboard bench for the weighted round-robin arbiter: directed cases plus
// randomized traffic against a behavioural credit/turn model.
module tb_arbiter_weighted_round_robin;

  localparam int CLIENTS  = 4;
  localparam int WEIGHT_W = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        blockArb = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] weight = '0;
  logic        gntAck = 1'b0;
  logic [3:0]  gnt;
  logic [1:0]  gntId;
  logic        gntValid;

  always #5 clk = ~clk;

  arbiter_weighted_round_robin #(
    .CLIENTS  (CLIENTS),
    .WEIGHT_W (WEIGHT_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_block_arb (blockArb),
    .i_req       (req),
    .i_weight    (weight),
    .i_gnt_ack   (gntAck),
    .o_gnt       (gnt),
    .o_gnt_id    (gntId),
    .o_gnt_valid (gntValid)
  );

  typedef struct {
    bit valid;
    int id;
  } expect_t;

  expect_t scoreQ[$];
  int nChecks = 0;
  int nPass   = 0;

  bit mGranted;
  int mOwner;
  int mLast;
  int mCredit[4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic void modelReset();
    mGranted = 1'b0;
    mOwner   = 0;
    mLast    = 3;
    for (int c = 0; c < 4; c++) mCredit[c] = 0;
  endfunction

  function automatic int pickNext(input logic [3:0] elig);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (mLast + k) % 4;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  function automatic int weightOf(input logic [15:0] w, input int c);
    int v;
    v = int'(w[c*4 +: 4]);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic void modelStep(input logic [3:0] r, input logic b, input logic a, input logic [15:0] w);
    logic [3:0] elig;
    elig = b ? 4'b0000 : r;
    if (!mGranted) begin
      if (elig != 0) begin
        mOwner   = pickNext(elig);
        mGranted = 1'b1;
        mCredit[mOwner] = weightOf(w, mOwner);
      end
    end else if (a) begin
      mCredit[mOwner] = mCredit[mOwner] - 1;
      if (!(mCredit[mOwner] > 0 && elig[mOwner])) begin
        mLast = mOwner;
        if (elig != 0) begin
          mOwner = pickNext(elig);
          mCredit[mOwner] = weightOf(w, mOwner);
        end else begin
          mGranted = 1'b0;
        end
      end
    end
  endfunction

  task automatic applyStimulus(input logic [3:0] r, input logic b, input logic a, input logic [15:0] w);
    @(negedge clk);
    req      = r;
    blockArb = b;
    gntAck   = a;
    weight   = w;
    modelStep(r, b, a, w);
    scoreQ.push_back('{valid: mGranted, id: mOwner});
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst      = 1'b1;
    req      = '0;
    blockArb = 1'b0;
    gntAck   = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset_gnt", 32'(gnt), 32'd0);
    checkOutput("reset_valid", 32'(gntValid), 32'd0);
    checkOutput("reset_gnt_id", 32'(gntId), 32'd0);
    rst = 1'b0;
  endtask

  initial begin : monitor
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        checkOutput("gnt_valid", 32'(gntValid), 32'(e.valid));
        checkOutput("gnt", 32'(gnt), e.valid ? (32'd1 << e.id) : 32'd0);
        if (e.valid) checkOutput("gnt_id", 32'(gntId), 32'(e.id));
      end
    end
  end

  initial begin : stimulus
    modelReset();

    // Equal weights: plain rotation 0,1,2,3,0.
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(4'b1111, 1'b0, 1'b1, 16'h1111);

    // Weights w0=3 w1=1 w2=2 w3=0: 0,0,0,1,2,2,3,0,0,0.
    resetDut();
    for (int i = 0; i < 11; i++) applyStimulus(4'b1111, 1'b0, 1'b1, 16'h0213);

    // Grant to client 2 is held without ack despite request drop and block.
    resetDut();
    applyStimulus(4'b0100, 1'b0, 1'b0, 16'h1111);
    for (int i = 0; i < 5; i++) applyStimulus(4'b0000, 1'b1, 1'b0, 16'h1111);
    applyStimulus(4'b0000, 1'b0, 1'b1, 16'h1111);

    // Sole requester keeps winning with credit reloads; block at ack idles.
    resetDut();
    for (int i = 0; i < 6; i++) applyStimulus(4'b0010, 1'b0, 1'b1, 16'h0020);
    applyStimulus(4'b0010, 1'b1, 1'b1, 16'h0020);
    applyStimulus(4'b0010, 1'b1, 1'b1, 16'h0020);

    // Asynchronous reset in the middle of a client-0 burst.
    resetDut();
    applyStimulus(4'b0001, 1'b0, 1'b0, 16'h0003);
    applyStimulus(4'b0001, 1'b0, 1'b1, 16'h0003);
    @(posedge clk);
    #3;
    rst    = 1'b1;
    req    = '0;
    gntAck = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_gnt", 32'(gnt), 32'd0);
    checkOutput("async_rst_valid", 32'(gntValid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'b1001, 1'b0, 1'b0, 16'h0003);
    applyStimulus(4'b1001, 1'b0, 1'b1, 16'h0003);

    // Randomized traffic, weights changing every cycle.
    resetDut();
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) == 0) resetDut();
      applyStimulus(4'($urandom), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 2) != 0), 16'($urandom));
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard_drain", 32'(scoreQ.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
